// File: rtl/mips_pkg.sv
// Shared types and encodings for the MIPS single-cycle core front end.
// Holds the fetch FSM states, main-decoder opcodes and Ne branch-kind codes.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] NE_BEQ  = 2'b00;
  localparam logic [1:0] NE_BNE  = 2'b01;
  localparam logic [1:0] NE_JUMP = 2'b10;

  // Word offset is sign-extended then scaled to bytes; the add wraps mod 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: sequential, conditional branch (beq/bne) or absolute jump.
// Purely combinational; no handshake.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic [1:0]  ne,
  input  logic        zero,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_plus4;
    if (branch) begin
      case (ne)
        NE_BEQ:  if (zero)  next_pc = branch_target(pc_plus4, instr[15:0]);
        NE_BNE:  if (!zero) next_pc = branch_target(pc_plus4, instr[15:0]);
        NE_JUMP: next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        default: next_pc = pc_plus4;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches over req/ack, holds the word through EXEC.
// Two cycles per instruction minimum; ack delay and stall each add a cycle.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic [1:0]  ne,
  input  logic        zero,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted
);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_halted;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  assign w_pc_plus4 = r_pc + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pc_plus4 (w_pc_plus4),
    .instr    (r_instr),
    .branch   (branch),
    .ne       (ne),
    .zero     (zero),
    .next_pc  (w_next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= 32'h0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            // Halt leaves pc pointing at the halt word itself.
            if (r_instr[31:26] == OP_HALT) begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= FETCH;
            end
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == EXEC);
  assign instr       = r_instr;
  assign opcode      = r_instr[31:26];
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: acts as instruction memory and control, and scores fetch
// addresses against a queue of expected next-PCs pushed as each instruction executes.
module tb_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [1:0]  ne = 2'b00;
  logic        zero = 1'b0;
  logic        imem_req, instr_valid, halted;
  logic [31:0] imem_addr, instr, pc, pc_plus4;
  logic [5:0]  opcode;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] word;
    logic        br;
    logic [1:0]  nei;
    logic        z;
    logic [31:0] nxt;
  } step_t;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .branch      (branch),
    .ne          (ne),
    .zero        (zero),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted)
  );

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  function automatic logic [31:0] mk_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  // Memory + control stimulus for one instruction; called at a negedge.
  task automatic serve(input logic [31:0] word, input int ack_dly, input int stall_n,
                       input logic br, input logic [1:0] ne_i, input logic z,
                       output logic [31:0] addr_seen, output int cycles, output bit got,
                       output bit addr_const, output bit held, output logic [31:0] pp4);
    int w = 0;
    got = 0; addr_const = 1; held = 1; cycles = 0; addr_seen = 32'hDEAD_BEEF; pp4 = 32'h0;
    while (!imem_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!imem_req) return;
    got = 1;
    addr_seen = imem_addr;
    repeat (ack_dly) begin
      @(negedge clk);
      cycles++;
      if (imem_addr !== addr_seen || imem_req !== 1'b1) addr_const = 0;
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    cycles++;
    if (instr !== word || instr_valid !== 1'b1 || pc !== addr_seen || imem_req !== 1'b0) held = 0;
    repeat (stall_n) begin
      stall = 1'b1;
      branch = $urandom; ne = $urandom; zero = $urandom;
      @(negedge clk);
      cycles++;
      if (instr !== word || instr_valid !== 1'b1 || pc !== addr_seen) held = 0;
    end
    pp4 = pc_plus4;
    stall = 1'b0;
    branch = br; ne = ne_i; zero = z;
    @(negedge clk);
    cycles++;
    branch = $urandom; ne = $urandom; zero = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (opcode !== 6'd0) begin errors++; $display("FAIL reset_opcode got %h exp 0", opcode); end
    rst_n = 1'b1;
    imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b exp 0", imem_req); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
    exp_q.push_back(32'h100);
  endtask

  task automatic test_sequential();
    step_t t[4];
    logic [31:0] a, e, pp;
    int cyc;
    bit got, ac, hd;
    t = '{'{mk_i(OP_ADDI, 16'h0001), 1'b0, 2'b00, 1'b0, 32'h104},
          '{mk_i(OP_ADDI, 16'h0002), 1'b0, 2'b00, 1'b1, 32'h108},
          '{mk_i(OP_RTYPE, 16'h0020), 1'b0, 2'b10, 1'b0, 32'h10C},
          '{mk_j(OP_J, 26'h000_0080), 1'b1, NE_JUMP, 1'b0, 32'h200}};
    foreach (t[i]) begin
      serve(t[i].word, 0, 0, t[i].br, t[i].nei, t[i].z, a, cyc, got, ac, hd, pp);
      e = exp_q.pop_front();
      checks++; if (!got || a !== e) begin errors++; $display("FAIL seq_addr_%0d got %h exp %h", i, a, e); end
      checks++; if (!hd || cyc != 2) begin errors++; $display("FAIL seq_exec_%0d held %0d cycles %0d exp 1 2", i, hd, cyc); end
      exp_q.push_back(t[i].nxt);
    end
  endtask

  task automatic test_beq();
    step_t t[3];
    logic [31:0] a, e, pp;
    int cyc;
    bit got, ac, hd;
    t = '{'{mk_i(OP_BEQ, 16'hFFFF), 1'b1, NE_BEQ, 1'b1, 32'h200},
          '{mk_i(OP_BEQ, 16'hFFFF), 1'b1, NE_BEQ, 1'b0, 32'h204},
          '{mk_j(OP_J, 26'h000_0010), 1'b1, NE_JUMP, 1'b1, 32'h40}};
    foreach (t[i]) begin
      serve(t[i].word, 0, 0, t[i].br, t[i].nei, t[i].z, a, cyc, got, ac, hd, pp);
      e = exp_q.pop_front();
      checks++; if (!got || a !== e) begin errors++; $display("FAIL beq_addr_%0d got %h exp %h", i, a, e); end
      exp_q.push_back(t[i].nxt);
    end
  endtask

  task automatic test_bne();
    step_t t[6];
    logic [31:0] a, e, pp;
    int cyc;
    bit got, ac, hd;
    t = '{'{mk_i(OP_BNE, 16'h0003), 1'b1, NE_BNE, 1'b1, 32'h44},
          '{mk_j(OP_J, 26'h000_0010), 1'b1, NE_JUMP, 1'b0, 32'h40},
          '{mk_i(OP_BNE, 16'h0003), 1'b1, NE_BNE, 1'b0, 32'h50},
          '{mk_j(OP_J, 26'h000_0000), 1'b1, NE_JUMP, 1'b0, 32'h0},
          '{mk_i(OP_BEQ, 16'h8000), 1'b1, NE_BEQ, 1'b1, 32'hFFFE_0004},
          '{mk_j(OP_J, 26'h000_0004), 1'b1, NE_JUMP, 1'b0, 32'hF000_0010}};
    foreach (t[i]) begin
      serve(t[i].word, 0, 0, t[i].br, t[i].nei, t[i].z, a, cyc, got, ac, hd, pp);
      e = exp_q.pop_front();
      checks++; if (!got || a !== e) begin errors++; $display("FAIL bne_addr_%0d got %h exp %h", i, a, e); end
      exp_q.push_back(t[i].nxt);
    end
  endtask

  task automatic test_jump();
    step_t t[5];
    logic [31:0] a, e, pp;
    int cyc;
    bit got, ac, hd;
    t = '{'{mk_j(OP_J, 26'h000_0040), 1'b1, NE_JUMP, 1'b0, 32'hF000_0100},
          '{mk_j(OP_J, 26'h000_0004), 1'b1, NE_JUMP, 1'b1, 32'hF000_0010},
          '{mk_j(OP_J, 26'h000_0040), 1'b1, 2'b11, 1'b1, 32'hF000_0014},
          '{mk_i(OP_BNE, 16'h0003), 1'b0, NE_BNE, 1'b0, 32'hF000_0018},
          '{mk_j(OP_J, 26'h3FF_FFFF), 1'b1, NE_JUMP, 1'b0, 32'hFFFF_FFFC}};
    foreach (t[i]) begin
      serve(t[i].word, 0, 0, t[i].br, t[i].nei, t[i].z, a, cyc, got, ac, hd, pp);
      e = exp_q.pop_front();
      checks++; if (!got || a !== e) begin errors++; $display("FAIL jump_addr_%0d got %h exp %h", i, a, e); end
      exp_q.push_back(t[i].nxt);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a, e, pp;
    int cyc;
    bit got, ac, hd;
    serve(mk_i(OP_ADDI, 16'h0007), 0, 0, 1'b0, 2'b00, 1'b0, a, cyc, got, ac, hd, pp);
    e = exp_q.pop_front();
    checks++; if (!got || a !== e) begin errors++; $display("FAIL wrap_addr got %h exp %h", a, e); end
    checks++; if (pp !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got %h exp 0", pp); end
    exp_q.push_back(32'h0);
  endtask

  task automatic test_delay_stall();
    logic [31:0] a, e, pp;
    int cyc;
    bit got, ac, hd;
    serve(mk_i(OP_LW, 16'h0010), 3, 2, 1'b0, 2'b00, 1'b0, a, cyc, got, ac, hd, pp);
    e = exp_q.pop_front();
    checks++; if (!got || a !== e) begin errors++; $display("FAIL ds_addr got %h exp %h", a, e); end
    checks++; if (!ac) begin errors++; $display("FAIL ds_addr_const got %0d exp 1", ac); end
    checks++; if (!hd) begin errors++; $display("FAIL ds_instr_stable got %0d exp 1", hd); end
    checks++; if (cyc != 7) begin errors++; $display("FAIL ds_cycles got %0d exp 7", cyc); end
    exp_q.push_back(32'h4);
  endtask

  task automatic test_halt();
    logic [31:0] a, e, pp;
    int cyc, w;
    bit got, ac, hd, quiet;
    serve(32'hFC00_0000, 0, 0, 1'b1, NE_JUMP, 1'b1, a, cyc, got, ac, hd, pp);
    e = exp_q.pop_front();
    checks++; if (!got || a !== e) begin errors++; $display("FAIL halt_addr got %h exp %h", a, e); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL halt_pc got %h exp 4", pc); end
    checks++; if (opcode !== OP_HALT) begin errors++; $display("FAIL halt_opcode got %h exp %h", opcode, OP_HALT); end
    quiet = 1;
    repeat (6) begin
      imem_ack = $urandom;
      @(negedge clk);
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b1) quiet = 0;
    end
    imem_ack = 1'b0;
    checks++; if (!quiet) begin errors++; $display("FAIL halt_quiet got %0d exp 1", quiet); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    while (!imem_req && w < 10) begin
      @(negedge clk);
      w++;
    end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL refetch req %b addr %h exp 1 100", imem_req, imem_addr); end
    imem_ack = 1'b1;
    imem_rdata = 32'hFC00_0000;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL midfetch_req_drop got %b exp 0", imem_req); end
    @(negedge clk);
    checks++; if (instr !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL midfetch_ack_ignored instr %h halted %b exp 0 0", instr, halted); end
    imem_ack = 1'b0;
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h100);
    serve(mk_i(OP_ADDI, 16'h0001), 1, 0, 1'b0, 2'b00, 1'b0, a, cyc, got, ac, hd, pp);
    e = exp_q.pop_front();
    checks++; if (!got || a !== e || cyc != 3) begin errors++; $display("FAIL restart addr %h cycles %0d exp %h 3", a, cyc, e); end
    exp_q.push_back(32'h104);
    serve(mk_i(OP_ADDI, 16'h0002), 0, 0, 1'b0, 2'b00, 1'b0, a, cyc, got, ac, hd, pp);
    e = exp_q.pop_front();
    checks++; if (!got || a !== e) begin errors++; $display("FAIL restart_next got %h exp %h", a, e); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_bne();
    test_jump();
    test_wrap();
    test_delay_stall();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

endmodule
